fmul_arbiter: RTL and testbench
===============================

Name: fmul_arbiter

Overview:
- Shares one pipelined 24-bit float multiplier datapath among NUM_REQ requesters. The multiplier is the existing adder/multiplier/normaliser/signbit pipeline with output flags.
- Each requester uses a valid/ready issue port. The block arbitrates round-robin, drives registered operands into the multiplier and tags every issue slot.
- Results return after the fixed pipeline latency and are routed back to the owning requester as a one-cycle response pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 4, cycles from mul_a/mul_b being driven to mul_result/flags being valid (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_en  in  1  1 = grants allowed this cycle; 0 = no new issue, in-flight ops still drain.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- req_a  in  24*NUM_REQ  operand A per requester, slice i = [24*i+23:24*i]; format sign[23], exp[22:16], mantissa[15:0].
- req_b  in  24*NUM_REQ  operand B per requester, same packing.
- mul_a  out  24  registered operand A to the multiplier.
- mul_b  out  24  registered operand B to the multiplier.
- mul_result  in  24  multiplier result.
- mul_overflow  in  1  multiplier overflow flag.
- mul_underflow  in  1  multiplier underflow flag.
- rsp_valid  out  NUM_REQ  one-hot response pulse, registered.
- rsp_data  out  24  registered result.
- rsp_overflow  out  1  registered overflow flag.
- rsp_underflow  out  1  registered underflow flag.
- in_flight  out  clog2(MUL_LATENCY+2)  count of issued ops not yet responded.

Behaviour:
- Reset (rst=0, async):
  - mul_a, mul_b, rsp_data = 0; rsp_valid = 0; rsp flags = 0; in_flight = 0.
  - Round-robin pointer = 0; all tag slots invalid.
- Arbitration (combinational):
  - Search from the pointer upward, with wrap, for the first i with req_valid[i]=1.
  - req_ready[i]=1 for that i only, and only if issue_en=1; otherwise req_ready = 0.
- Handshake:
  - Transfer when req_valid[i] && req_ready[i].
  - Requester holds valid, a and b stable until transfer. Deasserting valid before transfer is allowed; nothing is issued.
- On a transfer to requester g at edge T:
  - mul_a <= req_a[g], mul_b <= req_b[g].
  - Tag slot 0 <= {valid=1, id=g}.
  - Pointer <= (g+1) mod NUM_REQ.
- No transfer:
  - mul_a/mul_b hold their value; tag slot 0 <= invalid.
  - Pointer unchanged.
- Tag pipeline:
  - MUL_LATENCY+1 slots, shifting every cycle, never stalled.
  - The final slot aligns with mul_result.
- Response:
  - When the final slot is valid with id k, next edge: rsp_valid <= one-hot(k); rsp_data <= mul_result; rsp flags <= mul flags.
  - Otherwise rsp_valid <= 0, and rsp_data/flags hold.
- Latency: transfer at edge T → operands at T+1 → rsp_valid high for exactly one cycle after edge T+MUL_LATENCY+1.
- Throughput:
  - One issue per cycle; back-to-back grants allowed.
  - There is no response backpressure; requesters must accept rsp pulses.
- in_flight: +1 on transfer, −1 on rsp_valid pulse; both in the same cycle leaves it unchanged.
- Simultaneous requests from all requesters: each is served once per NUM_REQ cycles, with no starvation.
- issue_en falling mid-stream: in-flight ops complete normally and no new grants occur.
- Reset mid-operation clears all tags; results then emerging from the multiplier are discarded, and no rsp_valid is produced.
- NUM_REQ wrap: after granting NUM_REQ−1, the pointer becomes 0.

Test Plan:
Bench uses a behavioural multiplier stub: fixed MUL_LATENCY pipeline, result = a^b, overflow = a[23], underflow = b[23].
1. Single request: req_valid[2]=1, a=24'h3F0000, b=24'h012345 → req_ready[2] same cycle; mul_a=24'h3F0000 next cycle; rsp_valid=4'b0100, rsp_data=24'h3E2345 exactly MUL_LATENCY+2 cycles after the handshake cycle; in_flight 0→1→0.
2. All four valid continuously after reset → grant order 0,1,2,3,0,1…; four back-to-back responses, each routed to its issuer with correct data.
3. issue_en=0 with req_valid=4'b1111 → req_ready=0 and no mul_a change; raise issue_en → grant to requester 0 first.
4. Flags: a=24'h800001, b=24'h800002 → rsp_overflow=1, rsp_underflow=1, rsp_data=24'h000003.
5. Assert rst low with three ops in flight → outputs zero immediately; no rsp_valid after release; in_flight=0; pointer=0.
6. Requester 1 drops valid before grant while 3 is valid → only 3 is granted; no response to 1.

Source files
------------

// File: rtl/fmul_arbiter_if.sv
// Requester issue/response signals plus the shared multiplier operand/result
// bus of fmul_arbiter, bundled so the arbiter and its environment share one port.
interface fmul_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic                  issue_en;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [24*NUM_REQ-1:0] req_a;
   logic [24*NUM_REQ-1:0] req_b;
   logic [23:0]           mul_a;
   logic [23:0]           mul_b;
   logic [23:0]           mul_result;
   logic                  mul_overflow;
   logic                  mul_underflow;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [23:0]           rsp_data;
   logic                  rsp_overflow;
   logic                  rsp_underflow;

   // Environment side: requesters plus the multiplier datapath.
   modport master (
      output issue_en, req_valid, req_a, req_b,
      output mul_result, mul_overflow, mul_underflow,
      input  req_ready, mul_a, mul_b,
      input  rsp_valid, rsp_data, rsp_overflow, rsp_underflow
   );

   // Arbiter side.
   modport slave (
      input  issue_en, req_valid, req_a, req_b,
      input  mul_result, mul_overflow, mul_underflow,
      output req_ready, mul_a, mul_b,
      output rsp_valid, rsp_data, rsp_overflow, rsp_underflow
   );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one fixed-latency float multiplier among NUM_REQ
// requesters; a tag pipeline routes each result back to its issuer.
module fmul_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MUL_LATENCY = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   fmul_arbiter_if.slave                    bus,
   output logic [$clog2(MUL_LATENCY+2)-1:0] in_flight
);
   localparam int unsigned IW    = $clog2(NUM_REQ);
   localparam int unsigned NSLOT = MUL_LATENCY + 1;

   logic [IW-1:0]      ptr;
   logic [IW-1:0]      cand;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_hit;
   logic               xfer;
   logic [23:0]        sel_a;
   logic [23:0]        sel_b;
   logic               tag_valid [NSLOT];
   logic [IW-1:0]      tag_id    [NSLOT];
   logic               rsp_fire;
   logic [NUM_REQ-1:0] rsp_onehot;

   // First valid requester at or above the pointer, wrapping.
   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         cand = IW'((32'(ptr) + j) % NUM_REQ);
         if (!gnt_hit && bus.req_valid[cand]) begin
            gnt_hit = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign xfer = bus.issue_en && gnt_hit;

   always_comb begin
      bus.req_ready = '0;
      if (xfer) begin
         bus.req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_a = bus.req_a[24*i +: 24];
            sel_b = bus.req_b[24*i +: 24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mul_a <= '0;
         bus.mul_b <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         bus.mul_a <= sel_a;
         bus.mul_b <= sel_b;
         ptr       <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Tag slot s describes the operands issued s+1 edges ago; the last slot
   // lines up with mul_result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned s = 0; s < NSLOT; s++) begin
            tag_valid[s] <= 1'b0;
            tag_id[s]    <= '0;
         end
      end else begin
         tag_valid[0] <= xfer;
         tag_id[0]    <= gnt_idx;
         for (int unsigned s = 1; s < NSLOT; s++) begin
            tag_valid[s] <= tag_valid[s-1];
            tag_id[s]    <= tag_id[s-1];
         end
      end
   end

   assign rsp_fire = tag_valid[NSLOT-1];

   always_comb begin
      rsp_onehot = '0;
      rsp_onehot[tag_id[NSLOT-1]] = rsp_fire;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rsp_valid     <= '0;
         bus.rsp_data      <= '0;
         bus.rsp_overflow  <= 1'b0;
         bus.rsp_underflow <= 1'b0;
      end else begin
         bus.rsp_valid <= rsp_onehot;
         if (rsp_fire) begin
            bus.rsp_data      <= bus.mul_result;
            bus.rsp_overflow  <= bus.mul_overflow;
            bus.rsp_underflow <= bus.mul_underflow;
         end
      end
   end

   // The count drops on the edge that raises rsp_valid, so it never exceeds
   // MUL_LATENCY+1 and fits the port width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_flight <= '0;
      end else begin
         case ({xfer, rsp_fire})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end
endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: table vectors, directed corner sequences and random
// traffic, all checked against a scoreboard model with a behavioural multiplier.
module tb_fmul_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned L  = 4;
   localparam int unsigned CW = $clog2(L + 2);

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] in_flight;
   int            n_cmp = 0;
   int            n_bad = 0;

   fmul_arbiter_if #(.NUM_REQ(N)) bus ();

   fmul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .in_flight (in_flight)
   );

   always #5 clk = ~clk;

   // Multiplier stub: result = a^b, overflow = a[23], underflow = b[23], L stages.
   logic [25:0] stub [L];
   always @(posedge clk) begin
      stub[0] <= {bus.mul_a[23], bus.mul_b[23], bus.mul_a ^ bus.mul_b};
      for (int i = 1; i < L; i++) stub[i] <= stub[i-1];
   end
   assign bus.mul_result    = stub[L-1][23:0];
   assign bus.mul_underflow = stub[L-1][24];
   assign bus.mul_overflow  = stub[L-1][25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
      bus.req_a[24*i +: 24] = a;
      bus.req_b[24*i +: 24] = b;
   endtask

   function automatic logic [23:0] opa(input int i);
      return 24'(32'h0A0000 + i * 32'h1111);
   endfunction

   function automatic logic [23:0] opb(input int i);
      return 24'(32'h005000 + i * 32'h0203);
   endfunction

   // ---------------- scoreboard model (evaluated at each falling edge) -------------
   typedef struct {
      int          due;
      int          id;
      logic [23:0] data;
      logic        ov;
      logic        un;
   } exp_rsp_t;

   exp_rsp_t     q[$];
   int           m_ptr, m_inflight, ncyc = 0, g_last = -1, k, g;
   logic [23:0]  m_mul_a, m_mul_b, m_rsp_data, ga, gb;
   logic         m_ov, m_un;
   logic [N-1:0] m_rsp_valid, m_ready;

   always @(negedge clk) begin
      if (!rst) begin
         m_ptr = 0; m_inflight = 0; q.delete();
         m_mul_a = '0; m_mul_b = '0; m_rsp_data = '0; m_ov = 1'b0; m_un = 1'b0;
      end
      m_rsp_valid = '0;
      if (q.size() != 0 && q[0].due == ncyc) begin
         m_rsp_valid[q[0].id] = 1'b1;
         m_rsp_data = q[0].data;
         m_ov = q[0].ov;
         m_un = q[0].un;
         m_inflight--;
         void'(q.pop_front());
      end
      chk("m_mul_a", 32'(bus.mul_a), 32'(m_mul_a));
      chk("m_mul_b", 32'(bus.mul_b), 32'(m_mul_b));
      chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
      chk("m_rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
      chk("m_rsp_flags", 32'({bus.rsp_overflow, bus.rsp_underflow}), 32'({m_ov, m_un}));
      chk("m_in_flight", 32'(in_flight), 32'(m_inflight));
      m_ready = '0;
      g_last  = -1;
      g       = -1;
      if (rst && bus.issue_en) begin
         for (int j = 0; j < N; j++) begin
            k = (m_ptr + j) % N;
            if (g < 0 && bus.req_valid[k]) g = k;
         end
      end
      if (g >= 0) m_ready[g] = 1'b1;
      if (rst) chk("m_req_ready", 32'(bus.req_ready), 32'(m_ready));
      if (g >= 0) begin
         ga = bus.req_a[24*g +: 24];
         gb = bus.req_b[24*g +: 24];
         m_mul_a = ga;
         m_mul_b = gb;
         q.push_back('{ncyc + L + 2, g, ga ^ gb, ga[23], gb[23]});
         m_inflight++;
         m_ptr  = (g + 1) % N;
         g_last = g;
      end
      ncyc++;
   end

   // ---------------- stimulus -------------------------------------------------------
   typedef struct {
      logic         en;
      logic [N-1:0] valid;
      logic [N-1:0] ready;
   } vec_t;

   vec_t        tv [14];
   logic [23:0] cur_a [N];
   logic [23:0] cur_b [N];
   logic [23:0] exp_a;
   int          t2_cnt = 0;

   task automatic collect();
      if (bus.rsp_valid != '0) begin
         chk("t2_route", 32'(bus.rsp_valid), 32'(1 << (t2_cnt % N)));
         chk("t2_data", 32'(bus.rsp_data), 32'(opa(int'(t2_cnt % N)) ^ opb(int'(t2_cnt % N))));
         t2_cnt++;
      end
   endtask

   initial begin
      int cnt1, cnt3, pulses, w;
      tv[0]  = '{1'b1, 4'b0000, 4'b0000};
      tv[1]  = '{1'b0, 4'b1111, 4'b0000};
      tv[2]  = '{1'b1, 4'b1111, 4'b0001};
      tv[3]  = '{1'b1, 4'b1111, 4'b0010};
      tv[4]  = '{1'b1, 4'b1000, 4'b1000};
      tv[5]  = '{1'b1, 4'b0110, 4'b0010};
      tv[6]  = '{1'b1, 4'b0001, 4'b0001};
      tv[7]  = '{1'b1, 4'b0001, 4'b0001};
      tv[8]  = '{1'b0, 4'b0100, 4'b0000};
      tv[9]  = '{1'b1, 4'b0100, 4'b0100};
      tv[10] = '{1'b1, 4'b1111, 4'b1000};
      tv[11] = '{1'b1, 4'b0011, 4'b0001};
      tv[12] = '{1'b1, 4'b0011, 4'b0010};
      tv[13] = '{1'b1, 4'b0000, 4'b0000};

      rst = 1'b0; bus.issue_en = 1'b0; bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
      repeat (2) cyc();
      chk("rst_mul_a", 32'(bus.mul_a), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      chk("rst_in_flight", 32'(in_flight), 32'h0);
      rst = 1'b1;

      // Table vectors; operands only change while the requester is idle or just granted.
      exp_a = '0;
      for (int i = 0; i < N; i++) begin cur_a[i] = '0; cur_b[i] = '0; end
      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r == 0 || !tv[r-1].valid[i] || tv[r-1].ready[i]) begin
               cur_a[i] = 24'(r * 256 + i * 16 + 1);
               cur_b[i] = 24'(32'hF00000 ^ (r * 4096 + i));
            end
            set_op(i, cur_a[i], cur_b[i]);
         end
         bus.issue_en  = tv[r].en;
         bus.req_valid = tv[r].valid;
         #1 chk("tv_ready", 32'(bus.req_ready), 32'(tv[r].ready));
         for (int i = 0; i < N; i++) if (tv[r].ready[i]) exp_a = cur_a[i];
         cyc();
         chk("tv_mul_a", 32'(bus.mul_a), 32'(exp_a));
      end

      rst = 1'b0; cyc(); rst = 1'b1;

      // issue_en low blocks grants; then all four stream round-robin from 0.
      for (int i = 0; i < N; i++) set_op(i, opa(i), opb(i));
      bus.issue_en = 1'b0; bus.req_valid = 4'b1111;
      #1 chk("t3_ready_off", 32'(bus.req_ready), 32'h0);
      cyc();
      chk("t3_mul_a_hold", 32'(bus.mul_a), 32'h0);
      bus.issue_en = 1'b1;
      for (int n = 0; n < 6; n++) begin
         #1 chk("t2_grant", 32'(bus.req_ready), 32'(1 << (n % N)));
         cyc();
         chk("t2_mul_a", 32'(bus.mul_a), 32'(opa(n % N)));
         collect();
      end
      bus.req_valid = '0;
      repeat (8) begin cyc(); collect(); end
      chk("t2_rsp_count", 32'(t2_cnt), 32'd6);

      // Single request, exact latency.
      bus.req_valid = 4'b0100; set_op(2, 24'h3F0000, 24'h012345);
      #1 chk("t1_ready", 32'(bus.req_ready), 32'b0100);
      cyc();
      bus.req_valid = '0;
      chk("t1_mul_a", 32'(bus.mul_a), 32'h3F0000);
      chk("t1_in_flight_1", 32'(in_flight), 32'd1);
      repeat (L) cyc();
      chk("t1_early", 32'(bus.rsp_valid), 32'h0);
      cyc();
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
      chk("t1_rsp_data", 32'(bus.rsp_data), 32'h3E2345);
      chk("t1_in_flight_0", 32'(in_flight), 32'd0);
      cyc();
      chk("t1_one_pulse", 32'(bus.rsp_valid), 32'h0);

      // Flags.
      bus.req_valid = 4'b0001; set_op(0, 24'h800001, 24'h800002);
      #1 chk("t4_ready", 32'(bus.req_ready), 32'b0001);
      cyc();
      bus.req_valid = '0;
      w = 0;
      while (bus.rsp_valid == '0 && w < 20) begin cyc(); w++; end
      chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
      chk("t4_rsp_data", 32'(bus.rsp_data), 32'h000003);
      chk("t4_flags", 32'({bus.rsp_overflow, bus.rsp_underflow}), 32'b11);

      // Requester 1 withdraws before being granted; only 3 is served.
      bus.issue_en = 1'b0; bus.req_valid = 4'b1010;
      set_op(1, 24'h111111, 24'h222222); set_op(3, 24'h333333, 24'h444444);
      #1 chk("t6_ready_off", 32'(bus.req_ready), 32'h0);
      cyc();
      bus.issue_en = 1'b1; bus.req_valid = 4'b1000;
      #1 chk("t6_ready", 32'(bus.req_ready), 32'b1000);
      cyc();
      bus.req_valid = '0;
      cnt1 = 0; cnt3 = 0;
      repeat (L + 4) begin
         cyc();
         if (bus.rsp_valid[1]) cnt1++;
         if (bus.rsp_valid[3]) cnt3++;
      end
      chk("t6_rsp_req1", 32'(cnt1), 32'd0);
      chk("t6_rsp_req3", 32'(cnt3), 32'd1);

      // Reset with three ops in flight.
      for (int i = 0; i < N; i++) set_op(i, opa(i), opb(i));
      bus.req_valid = 4'b0111;
      repeat (3) cyc();
      bus.req_valid = '0;
      cyc();
      chk("t5_in_flight_3", 32'(in_flight), 32'd3);
      rst = 1'b0;
      #1;
      chk("t5_mul_a", 32'(bus.mul_a), 32'h0);
      chk("t5_mul_b", 32'(bus.mul_b), 32'h0);
      chk("t5_rsp_data", 32'(bus.rsp_data), 32'h0);
      chk("t5_in_flight", 32'(in_flight), 32'h0);
      repeat (2) cyc();
      rst = 1'b1;
      pulses = 0;
      repeat (L + 6) begin cyc(); if (bus.rsp_valid != '0) pulses++; end
      chk("t5_no_rsp", 32'(pulses), 32'd0);
      chk("t5_in_flight_end", 32'(in_flight), 32'd0);
      bus.req_valid = 4'b1111;
      #1 chk("t5_ptr_zero", 32'(bus.req_ready), 32'b0001);
      bus.req_valid = '0;

      // Random traffic against the scoreboard.
      for (int c = 0; c < 400; c++) begin
         cyc();
         bus.issue_en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < N; i++) begin
            if (!bus.req_valid[i] || g_last == i) begin
               bus.req_valid[i] = 1'($urandom_range(0, 1));
               set_op(i, 24'($urandom), 24'($urandom));
            end else if ($urandom_range(0, 15) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
      end
      cyc();
      bus.req_valid = '0;
      repeat (L + 4) cyc();
      chk("rnd_drained", 32'(in_flight), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at %0t, required completion", $time);
      $fatal(1);
   end
endmodule
